// File: rtl/cpu_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_scheduler
// Purpose  : Paces the 6502 against the TIA colour clock: CPU clock enable,
//            WSYNC line-wait stall and external ROM fetch stall.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_scheduler #(
    parameter int         CPU_DIV       = 3,      // colour clocks per CPU cycle, >= 2
    parameter logic [5:0] WSYNC_ADDR    = 6'h02,
    parameter logic [7:0] HCOUNT_RESUME = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  hcount,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_we,
    output logic        cpu_ce,
    output logic        stall_cpu,
    output logic        rom_req,
    output logic [11:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic [7:0]  rom_di
);

    localparam int                 c_div_w    = $clog2(CPU_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CPU_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FETCH = 2'd1,
        ST_WSYNC = 2'd2
    } state_t;

    state_t               r_state_q,    w_state_d;
    logic [c_div_w-1:0]   r_div_q,      w_div_d;
    logic                 r_hit_q,      w_hit_d;
    logic                 r_rom_req_q,  w_rom_req_d;
    logic [11:0]          r_rom_addr_q, w_rom_addr_d;
    logic [7:0]           r_rom_di_q,   w_rom_di_d;
    logic                 r_stall_q,    w_stall_d;

    logic w_boundary;
    logic w_rom_rd;
    logic w_wsync;
    logic w_hit_valid;

    assign w_boundary  = (r_div_q == c_div_last);
    assign w_rom_rd    = cpu_addr[12] & ~cpu_we;
    assign w_wsync     = ~cpu_addr[12] & ~cpu_addr[7] & cpu_we & (cpu_addr[5:0] == WSYNC_ADDR);
    assign w_hit_valid = r_hit_q & (r_rom_addr_q == cpu_addr[11:0]);

    // A ROM read is only released once its byte is latched for this address.
    assign cpu_ce = (r_state_q == ST_RUN) & w_boundary & ~(w_rom_rd & ~w_hit_valid);

    always_comb begin
        w_state_d    = r_state_q;
        w_div_d      = w_boundary ? '0 : r_div_q + c_div_w'(1);
        w_hit_d      = r_hit_q;
        w_rom_req_d  = r_rom_req_q;
        w_rom_addr_d = r_rom_addr_q;
        w_rom_di_d   = r_rom_di_q;

        case (r_state_q)
            ST_RUN: begin
                if (w_boundary) begin
                    if (w_rom_rd && !w_hit_valid) begin
                        w_rom_addr_d = cpu_addr[11:0];
                        w_rom_req_d  = 1'b1;
                        w_state_d    = ST_FETCH;
                    end else begin
                        // Any completed access consumes the latched byte.
                        w_hit_d = 1'b0;
                        if (w_wsync) begin
                            w_state_d = ST_WSYNC;
                        end
                    end
                end
            end
            ST_FETCH: begin
                if (rom_ack) begin
                    w_rom_di_d  = rom_data;
                    w_hit_d     = 1'b1;
                    w_rom_req_d = 1'b0;
                    w_state_d   = ST_RUN;
                end
            end
            ST_WSYNC: begin
                if (hcount == HCOUNT_RESUME) begin
                    w_state_d = ST_RUN;
                    w_div_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_RUN;
            end
        endcase

        w_stall_d = (w_state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_RUN;
            r_div_q      <= '0;
            r_hit_q      <= 1'b0;
            r_rom_req_q  <= 1'b0;
            r_rom_addr_q <= '0;
            r_rom_di_q   <= '0;
            r_stall_q    <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_div_q      <= w_div_d;
            r_hit_q      <= w_hit_d;
            r_rom_req_q  <= w_rom_req_d;
            r_rom_addr_q <= w_rom_addr_d;
            r_rom_di_q   <= w_rom_di_d;
            r_stall_q    <= w_stall_d;
        end
    end

    assign stall_cpu = r_stall_q;
    assign rom_req   = r_rom_req_q;
    assign rom_addr  = r_rom_addr_q;
    assign rom_di    = r_rom_di_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_scheduler
// Purpose  : Directed and randomized bench for cpu_bus_scheduler with a
//            behavioural model compared every colour clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_scheduler;

    localparam int         CPU_DIV       = 3;
    localparam logic [5:0] WSYNC_ADDR    = 6'h02;
    localparam logic [7:0] HCOUNT_RESUME = 8'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hcount;
    logic [12:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_ce;
    logic        stall_cpu;
    logic        rom_req;
    logic [11:0] rom_addr;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic [7:0]  rom_di;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_bus_scheduler #(
        .CPU_DIV       (CPU_DIV),
        .WSYNC_ADDR    (WSYNC_ADDR),
        .HCOUNT_RESUME (HCOUNT_RESUME)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_ce    (cpu_ce),
        .stall_cpu (stall_cpu),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .rom_di    (rom_di)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ROM responder state
    bit         resp_busy = 1'b0;
    int         resp_cnt  = 0;
    logic [7:0] resp_data = 8'h00;
    int         resp_fixed_lat  = 0;
    logic [7:0] resp_fixed_data = 8'h00;
    bit         spur_en = 1'b0;

    // Advance one colour clock: TIA counter and ROM side are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
        hcount  = (hcount == 8'd227) ? 8'd0 : hcount + 8'd1;
        rom_ack = 1'b0;
        if (resp_busy) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                rom_ack   = 1'b1;
                rom_data  = resp_data;
                resp_busy = 1'b0;
            end
        end else if (rom_req === 1'b1) begin
            resp_busy = 1'b1;
            resp_cnt  = (resp_fixed_lat > 0) ? resp_fixed_lat : int'($urandom_range(1, 6));
            resp_data = (resp_fixed_lat > 0) ? resp_fixed_data : 8'($urandom);
        end else if (spur_en && $urandom_range(0, 15) == 0) begin
            rom_ack  = 1'b1;
            rom_data = 8'($urandom);
        end
    endtask

    task automatic wait_ce(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cpu_ce) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_ce_or_req(input int budget, output bit got_ce, output bit got_req);
        got_ce  = 1'b0;
        got_req = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cpu_ce) begin
                got_ce = 1'b1;
                return;
            end
            if (rom_req) begin
                got_req = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Behavioural model: CPU-cycle phase derived from clocks since the last
    // re-phase point, plus pending-fetch / line-wait flags and a one-byte cache.
    bit          m_known = 1'b0;
    int          m_cyc = 0;
    bit          m_fetching = 1'b0;
    bit          m_in_wsync = 1'b0;
    bit          m_cache_valid = 1'b0;
    logic [11:0] m_cache_addr = '0;
    logic [11:0] m_req_addr = '0;
    logic [7:0]  m_cache_data = '0;

    initial begin : compare_proc
        bit rd, ws, hitv, bnd, exp_ce;
        forever begin
            @(negedge clk);
            rd     = cpu_addr[12] && !cpu_we;
            ws     = !cpu_addr[12] && !cpu_addr[7] && cpu_we && (cpu_addr[5:0] == WSYNC_ADDR);
            hitv   = m_cache_valid && (m_cache_addr == cpu_addr[11:0]);
            bnd    = (m_cyc % CPU_DIV) == (CPU_DIV - 1);
            exp_ce = !m_fetching && !m_in_wsync && bnd && !(rd && !hitv);
            if (m_known) begin
                check("model_cpu_ce",    cpu_ce,    exp_ce);
                check("model_stall_cpu", stall_cpu, m_fetching || m_in_wsync);
                check("model_rom_req",   rom_req,   m_fetching);
                check("model_rom_addr",  rom_addr,  m_req_addr);
                check("model_rom_di",    rom_di,    m_cache_data);
            end
            if (reset) begin
                m_known       = 1'b1;
                m_cyc         = 0;
                m_fetching    = 1'b0;
                m_in_wsync    = 1'b0;
                m_cache_valid = 1'b0;
                m_cache_addr  = '0;
                m_req_addr    = '0;
                m_cache_data  = '0;
            end else if (m_known) begin
                m_cyc++;
                if (m_in_wsync) begin
                    if (hcount == HCOUNT_RESUME) begin
                        m_in_wsync = 1'b0;
                        m_cyc      = 0;
                    end
                end else if (m_fetching) begin
                    if (rom_ack) begin
                        m_fetching    = 1'b0;
                        m_cache_valid = 1'b1;
                        m_cache_addr  = m_req_addr;
                        m_cache_data  = rom_data;
                    end
                end else if (bnd) begin
                    if (rd && !hitv) begin
                        m_fetching = 1'b1;
                        m_req_addr = cpu_addr[11:0];
                    end else begin
                        m_cache_valid = 1'b0;
                        if (ws) m_in_wsync = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [8:0]  ce_pat;
        logic [11:0] rom_pool [4];
        bit          ok, got_ce, got_req, done, ce_prev;
        int          n, r;

        rom_pool = '{12'hFFC, 12'h000, 12'h234, 12'h7A1};
        reset    = 1'b1;
        hcount   = 8'd0;
        cpu_addr = 13'h0080;
        cpu_we   = 1'b0;
        rom_ack  = 1'b0;
        rom_data = 8'h00;

        // Reset for two edges, then cpu_ce at clocks 2, 5, 8 after release.
        tick();
        tick();
        reset  = 1'b0;
        ce_pat = 9'b100100100;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check("reset_ce_pattern", cpu_ce, ce_pat[k]);
            check("reset_stall", stall_cpu, 1'b0);
            check("reset_rom_req", rom_req, 1'b0);
            if (k == 0) begin
                check("reset_rom_addr", rom_addr, 12'h000);
                check("reset_rom_di", rom_di, 8'h00);
            end
            tick();
        end

        // ROM read of 1FFC, ack 4 clocks after request with A5 (boundary at clk 11).
        cpu_addr        = 13'h1FFC;
        resp_fixed_lat  = 4;
        resp_fixed_data = 8'hA5;
        for (int k = 9; k <= 17; k++) begin
            @(negedge clk);
            check("rom_ce", cpu_ce, (k == 17));
            check("rom_req_window", rom_req, (k >= 12 && k <= 16));
            check("rom_stall_window", stall_cpu, (k >= 12 && k <= 16));
            if (k == 12) check("rom_addr_fetch", rom_addr, 12'hFFC);
            if (k == 17) check("rom_di_after_ack", rom_di, 8'hA5);
            tick();
        end
        cpu_addr       = 13'h0080;
        resp_fixed_lat = 0;

        // WSYNC write at hcount=10: re-align so the boundary lands there.
        reset = 1'b1;
        n = 0;
        while (hcount != 8'd7 && n < 300) begin
            tick();
            n++;
        end
        tick();
        reset    = 1'b0;
        cpu_addr = 13'h0042;
        cpu_we   = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("wsync_hc10_hcount", hcount, 8'd10);
        check("wsync_write_ce", cpu_ce, 1'b1);
        tick();
        cpu_addr = 13'h0080;
        cpu_we   = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            check("wsync_hold_ce", cpu_ce, 1'b0);
            check("wsync_hold_stall", stall_cpu, 1'b1);
            done = (hcount == 8'd0);
            tick();
            n++;
        end
        check("wsync_released_in_time", done, 1'b1);
        @(negedge clk);
        check("wsync_resume_stall", stall_cpu, 1'b0);
        check("wsync_resume_ce0", cpu_ce, 1'b0);
        tick();
        @(negedge clk);
        check("wsync_resume_ce1", cpu_ce, 1'b0);
        tick();
        @(negedge clk);
        check("wsync_resume_ce2", cpu_ce, 1'b1);

        // WSYNC issued on the boundary where hcount==0: a full line stall.
        tick();
        n = 0;
        while (hcount != 8'd226 && n < 300) begin
            tick();
            n++;
        end
        cpu_addr = 13'h0F42;
        cpu_we   = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("wsync_hc0_ce", cpu_ce, 1'b1);
        tick();
        cpu_addr = 13'h0080;
        cpu_we   = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!stall_cpu) break;
            n++;
            tick();
        end
        check("wsync_full_line_len", n, 228);

        // Reset two clocks into a fetch; the late ack must be ignored.
        tick();
        cpu_addr        = 13'h1234;
        resp_fixed_lat  = 6;
        resp_fixed_data = 8'h5A;
        wait_ce_or_req(20, got_ce, got_req);
        check("midfetch_req_seen", got_req, 1'b1);
        tick();
        tick();
        reset    = 1'b1;
        cpu_addr = 13'h0080;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midfetch_req_dropped", rom_req, 1'b0);
        check("midfetch_stall_dropped", stall_cpu, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check("late_ack_rom_di", rom_di, 8'h00);
        check("late_ack_stall", stall_cpu, 1'b0);
        check("late_ack_req", rom_req, 1'b0);

        // ROM addr 000 must not falsely hit after the ignored ack.
        tick();
        cpu_addr        = 13'h1000;
        resp_fixed_lat  = 3;
        resp_fixed_data = 8'h3C;
        wait_ce_or_req(10, got_ce, got_req);
        check("no_stale_hit_after_reset", got_req, 1'b1);
        tick();
        wait_ce(20, ok);
        check("hit_ce_seen", ok, 1'b1);
        check("hit_data", rom_di, 8'h3C);
        tick();
        cpu_addr = 13'h0080;
        wait_ce(10, ok);
        check("ram_ce_seen", ok, 1'b1);
        tick();
        cpu_addr = 13'h1000;
        wait_ce_or_req(10, got_ce, got_req);
        check("refetch_after_clear", got_req, 1'b1);
        tick();
        wait_ce(20, ok);
        check("refetch_ce_seen", ok, 1'b1);

        // Randomized traffic against the model.
        resp_fixed_lat = 0;
        spur_en        = 1'b1;
        ce_prev        = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            tick();
            reset = ($urandom_range(0, 599) == 0);
            if (ce_prev || reset) begin
                r = int'($urandom_range(0, 99));
                if (r < 35) begin
                    cpu_addr = {1'b1, rom_pool[$urandom_range(0, 3)]};
                    cpu_we   = 1'b0;
                end else if (r < 36) begin
                    cpu_addr = {1'b0, 4'($urandom), 1'b0, 1'($urandom), WSYNC_ADDR};
                    cpu_we   = 1'b1;
                end else if (r < 40) begin
                    cpu_addr = {1'b1, 12'($urandom)};
                    cpu_we   = 1'b1;
                end else begin
                    cpu_addr = {1'b0, 12'($urandom)};
                    cpu_we   = 1'($urandom);
                end
            end
            @(negedge clk);
            ce_prev = cpu_ce;
        end
        reset = 1'b0;
        tick();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_bus_scheduler.md
Name: cpu_bus_scheduler

Overview:
- Sequences the 6502 core against the TIA color clock and the external ROM port.
- Generates the CPU clock enable as one pulse per CPU_DIV color clocks.
- Stalls the CPU for WSYNC (resume at the next scanline start) and for multi-cycle external ROM fetches over a req/ack handshake.
- Sits between the CPU, the TIA horizontal counter and the uio-pin ROM interface; drives the top-level stall_cpu signal.

Parameters:
- CPU_DIV, 3: color clocks per CPU cycle; must be ≥ 2.
- WSYNC_ADDR, 6'h02: TIA register offset (addr[5:0]) that triggers WSYNC.
- HCOUNT_RESUME, 0: hcount value on which a WSYNC stall releases.

Ports:
- clk  in  1  color clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- hcount  in  8  TIA horizontal counter, 0..227; advances by 1 every clk.
- cpu_addr  in  13  CPU address bus.
- cpu_we  in  1  CPU write strobe.
- cpu_ce  out  1  CPU clock enable; one clk wide.
- stall_cpu  out  1  high while state != RUN.
- rom_req  out  1  external ROM read request.
- rom_addr  out  12  ROM offset (cpu_addr[11:0]); held stable while rom_req=1.
- rom_ack  in  1  ROM data valid; one clk pulse.
- rom_data  in  8  ROM data, sampled when rom_ack=1.
- rom_di  out  8  latched ROM byte for the CPU data-in mux.

Behaviour:
- Reset values: state=RUN, div=0, hit=0, cpu_ce=0, stall_cpu=0, rom_req=0, rom_addr=0, rom_di=0.
- Reset asserted mid-fetch: rom_req drops on the next edge; a late rom_ack is ignored.
- Divider: div counts 0..CPU_DIV-1 and wraps, every clk, in all states. The boundary is the cycle where div==CPU_DIV-1.
- Decode:
  - rom_rd = cpu_addr[12] & ~cpu_we.
  - wsync = ~cpu_addr[12] & ~cpu_addr[7] & cpu_we & (cpu_addr[5:0]==WSYNC_ADDR). All TIA mirrors qualify.
- cpu_ce is combinational: (state==RUN) & boundary & ~(rom_rd & ~(hit & rom_addr==cpu_addr[11:0])).
- State RUN, at a boundary:
  - rom_rd with no valid hit: cpu_ce=0. Load rom_addr, set rom_req=1, go to FETCH.
  - rom_rd with a valid hit: cpu_ce=1, clear hit. The CPU consumes rom_di.
  - wsync: cpu_ce=1 (the write completes), then go to WSYNC.
  - Otherwise: cpu_ce=1.
- State FETCH:
  - rom_req=1, rom_addr frozen. Wait indefinitely for rom_ack.
  - On rom_ack: rom_di<=rom_data, hit<=1, rom_req<=0, go to RUN.
  - The CPU is then released at the next boundary. Fetch latency therefore rounds up to whole CPU cycles.
- State WSYNC:
  - cpu_ce=0 throughout.
  - Exit to RUN on the first clk where hcount==HCOUNT_RESUME; div<=0 on that same edge.
  - WSYNC is entered one clk after the boundary. A write issued while hcount==HCOUNT_RESUME therefore waits a full line (228 clks).
- stall_cpu is registered and equals (next_state != RUN). It is high from the first stalled clk through the exit edge.
- Simultaneous events:
  - rom_ack while rom_req=0 or in RUN/WSYNC: ignored.
  - hit is cleared by any boundary with cpu_ce=1 that is not a ROM read, so stale data is never replayed.
- Only one access is decoded per boundary; rom_rd and wsync are mutually exclusive by decode.

Test Plan:
- Reset held 2 clks, then released with cpu_addr=13'h0080 (RAM read), CPU_DIV=3 -> cpu_ce pulses at clks 2, 5, 8 after release; stall_cpu=0; rom_req=0.
- ROM read at cpu_addr=13'h1FFC; ROM model acks 4 clks after req with data 8'hA5:
  - rom_req rises the clk after the boundary, with rom_addr=12'hFFC.
  - rom_di=8'hA5 after the ack.
  - cpu_ce fires at the first boundary after the ack.
  - stall_cpu is high for exactly the FETCH interval.
- Write to 13'h0042 (a WSYNC mirror) at hcount=10 -> cpu_ce=1 at that boundary, then no cpu_ce until hcount wraps to 0. Resume with div=0; the next cpu_ce arrives 2 clks later.
- WSYNC write at the boundary where hcount==0 -> stall lasts until the following hcount==0, 228 clks later.
- Reset asserted 2 clks into a FETCH; ack arrives afterwards -> rom_req=0 on the reset edge; rom_di stays 0; hit stays 0; state is RUN.
- ROM read of 13'h1000 hits, then the CPU reads 13'h0080, then reads 13'h1000 again -> the second ROM read refetches (rom_req rises again) because hit was cleared.
